// File: rtl/segment_write_controller.sv
// segment_write_controller
//   Sole write master for the 4-entry segment register file. Arbitrates CS/segment
//   load requests from the interrupt unit, the far-branch unit and the execution unit
//   with fixed priority (intr > br > ex). It issues one registered write per cycle and
//   generates the load side effects: a prefetch flush on a CS write, and an interrupt
//   inhibit that covers the instruction following an SS load.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   intr_valid/ready/data interrupt-entry CS load request
//   br_valid/ready/data   far branch/call/return CS load request
//   ex_valid/ready/id/data execution-unit segment load request
//   stall                 freezes all grants
//   instr_done            one-cycle pulse per retired instruction
//   sreg_we/write_id/write_data  register-file write port (registered)
//   prefetch_flush        pulse coincident with a CS write
//   irq_inhibit           interrupt sampling must be blocked
//   illegal_write         pulse: exec CS load was consumed and dropped
module segment_write_controller #(
  parameter logic [1:0] CS_ID = 2'd0,
  parameter logic [1:0] SS_ID = 2'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr_valid,
  output logic        intr_ready,
  input  logic [15:0] intr_data,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [15:0] br_data,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_id,
  input  logic [15:0] ex_data,
  input  logic        stall,
  input  logic        instr_done,
  output logic        sreg_we,
  output logic [1:0]  sreg_write_id,
  output logic [15:0] sreg_write_data,
  output logic        prefetch_flush,
  output logic        irq_inhibit,
  output logic        illegal_write
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic        we_d, we_q;
  logic [1:0]  id_d, id_q;
  logic [15:0] data_d, data_q;
  logic        flush_d, flush_q;
  logic        illegal_d, illegal_q;
  logic [1:0]  state_d, state_q;
  logic        grant_en;
  logic        ss_accept;

  // Readys are held low during reset so nothing is consumed while the block is cleared.
  assign grant_en   = ~stall & ~reset;
  assign intr_ready = grant_en & intr_valid;
  assign br_ready   = grant_en & br_valid & ~intr_valid;
  assign ex_ready   = grant_en & ex_valid & ~intr_valid & ~br_valid;

  assign ss_accept = ex_ready & (ex_id == SS_ID);

  always_comb begin
    we_d      = 1'b0;
    id_d      = 2'd0;
    data_d    = 16'd0;
    illegal_d = 1'b0;
    if (intr_ready) begin
      we_d   = 1'b1;
      id_d   = CS_ID;
      data_d = intr_data;
    end else if (br_ready) begin
      we_d   = 1'b1;
      id_d   = CS_ID;
      data_d = br_data;
    end else if (ex_ready) begin
      // Exec may not load CS: the request is consumed but turned into an error pulse.
      if (ex_id == CS_ID) begin
        illegal_d = 1'b1;
      end else begin
        we_d   = 1'b1;
        id_d   = ex_id;
        data_d = ex_data;
      end
    end
    flush_d = we_d & (id_d == CS_ID);
  end

  // Shadow FSM: ARMED covers the rest of the SS-loading instruction, HOLD the next one.
  always_comb begin
    state_d = state_q;
    if (intr_ready) begin
      state_d = S_IDLE;
    end else if (ss_accept) begin
      state_d = instr_done ? S_HOLD : S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (instr_done) state_d = S_HOLD;
        S_HOLD:  if (instr_done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q      <= 1'b0;
      id_q      <= 2'd0;
      data_q    <= 16'd0;
      flush_q   <= 1'b0;
      illegal_q <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      we_q      <= we_d;
      id_q      <= id_d;
      data_q    <= data_d;
      flush_q   <= flush_d;
      illegal_q <= illegal_d;
      state_q   <= state_d;
    end
  end

  assign sreg_we         = we_q;
  assign sreg_write_id   = id_q;
  assign sreg_write_data = data_q;
  assign prefetch_flush  = flush_q;
  assign illegal_write   = illegal_q;
  assign irq_inhibit     = (state_q != S_IDLE);

endmodule

// File: tb/tb_segment_write_controller.sv
module tb_segment_write_controller;

  logic        clk;
  logic        reset;
  logic        intr_valid, br_valid, ex_valid;
  logic        intr_ready, br_ready, ex_ready;
  logic [15:0] intr_data, br_data, ex_data;
  logic [1:0]  ex_id;
  logic        stall, instr_done;
  logic        sreg_we;
  logic [1:0]  sreg_write_id;
  logic [15:0] sreg_write_data;
  logic        prefetch_flush, irq_inhibit, illegal_write;

  int n_checks = 0;
  int n_errors = 0;

  segment_write_controller dut (
    .clk            (clk),
    .reset          (reset),
    .intr_valid     (intr_valid),
    .intr_ready     (intr_ready),
    .intr_data      (intr_data),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_data        (br_data),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_id          (ex_id),
    .ex_data        (ex_data),
    .stall          (stall),
    .instr_done     (instr_done),
    .sreg_we        (sreg_we),
    .sreg_write_id  (sreg_write_id),
    .sreg_write_data(sreg_write_data),
    .prefetch_flush (prefetch_flush),
    .irq_inhibit    (irq_inhibit),
    .illegal_write  (illegal_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    intr_valid = 1'b0;
    br_valid   = 1'b0;
    ex_valid   = 1'b0;
    stall      = 1'b0;
    instr_done = 1'b0;
  endtask

  task automatic check_readys(input string tag, input logic i, input logic b, input logic e);
    #1;
    check_eq({tag, ".intr_ready"}, 32'(intr_ready), 32'(i));
    check_eq({tag, ".br_ready"},   32'(br_ready),   32'(b));
    check_eq({tag, ".ex_ready"},   32'(ex_ready),   32'(e));
  endtask

  task automatic check_write(input string tag, input logic we, input logic [1:0] id,
                             input logic [15:0] data, input logic flush);
    check_eq({tag, ".we"}, 32'(sreg_we), 32'(we));
    if (we) begin
      check_eq({tag, ".id"},   32'(sreg_write_id),   32'(id));
      check_eq({tag, ".data"}, 32'(sreg_write_data), 32'(data));
    end
    check_eq({tag, ".flush"}, 32'(prefetch_flush), 32'(flush));
  endtask

  initial begin
    reset = 1'b1;
    intr_data = 16'h0; br_data = 16'h0; ex_data = 16'h0; ex_id = 2'd0;
    set_idle();
    tick();
    tick();
    check_write("rst", 1'b0, 2'd0, 16'h0, 1'b0);
    check_eq("rst.inhibit", 32'(irq_inhibit), 32'd0);
    check_eq("rst.illegal", 32'(illegal_write), 32'd0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      check_readys("idle", 1'b0, 1'b0, 1'b0);
      tick();
      check_write("idle", 1'b0, 2'd0, 16'h0, 1'b0);
      check_eq("idle.inhibit", 32'(irq_inhibit), 32'd0);
    end

    // Three-way contention: intr, then br, then ex, back to back
    intr_valid = 1'b1; intr_data = 16'h1234;
    br_valid   = 1'b1; br_data   = 16'h5678;
    ex_valid   = 1'b1; ex_id = 2'd1; ex_data = 16'h9ABC;
    check_readys("arb0", 1'b1, 1'b0, 1'b0);
    tick();
    intr_valid = 1'b0;
    check_write("arb0", 1'b1, 2'd0, 16'h1234, 1'b1);
    check_readys("arb1", 1'b0, 1'b1, 1'b0);
    tick();
    br_valid = 1'b0;
    check_write("arb1", 1'b1, 2'd0, 16'h5678, 1'b1);
    check_readys("arb2", 1'b0, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check_write("arb2", 1'b1, 2'd1, 16'h9ABC, 1'b0);
    tick();
    check_write("arb3", 1'b0, 2'd0, 16'h0, 1'b0);

    // SS load: inhibit spans to the cycle after the second instr_done
    ex_valid = 1'b1; ex_id = 2'd2; ex_data = 16'h2000;
    check_readys("ss", 1'b0, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check_write("ss", 1'b1, 2'd2, 16'h2000, 1'b0);
    check_eq("ss.inh_n1", 32'(irq_inhibit), 32'd1);
    tick();
    check_eq("ss.inh_armed", 32'(irq_inhibit), 32'd1);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_eq("ss.inh_hold", 32'(irq_inhibit), 32'd1);
    tick();
    check_eq("ss.inh_hold2", 32'(irq_inhibit), 32'd1);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    check_eq("ss.inh_drop", 32'(irq_inhibit), 32'd0);

    // Illegal CS load from exec
    ex_valid = 1'b1; ex_id = 2'd0; ex_data = 16'hBEEF;
    check_readys("ill", 1'b0, 1'b0, 1'b1);
    tick();
    ex_valid = 1'b0;
    check_write("ill", 1'b0, 2'd0, 16'h0, 1'b0);
    check_eq("ill.pulse", 32'(illegal_write), 32'd1);
    tick();
    check_eq("ill.pulse_end", 32'(illegal_write), 32'd0);

    // Stall freezes all grants
    intr_valid = 1'b1; intr_data = 16'hF00D;
    br_valid = 1'b1; ex_valid = 1'b1; ex_id = 2'd3; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_readys("stall", 1'b0, 1'b0, 1'b0);
      tick();
      check_write("stall", 1'b0, 2'd0, 16'h0, 1'b0);
    end
    stall = 1'b0;
    check_readys("unstall", 1'b1, 1'b0, 1'b0);
    tick();
    set_idle();
    check_write("unstall", 1'b1, 2'd0, 16'hF00D, 1'b1);

    // Interrupt accept cancels an armed shadow
    ex_valid = 1'b1; ex_id = 2'd2; ex_data = 16'h3000;
    tick();
    ex_valid = 1'b0;
    check_eq("cancel.armed", 32'(irq_inhibit), 32'd1);
    intr_valid = 1'b1; intr_data = 16'h0040;
    tick();
    intr_valid = 1'b0;
    check_eq("cancel.inh", 32'(irq_inhibit), 32'd0);
    check_write("cancel", 1'b1, 2'd0, 16'h0040, 1'b1);

    // SS load with instr_done in the same cycle goes straight to HOLD, then reset
    ex_valid = 1'b1; ex_id = 2'd2; ex_data = 16'h4000; instr_done = 1'b1;
    tick();
    ex_valid = 1'b0; instr_done = 1'b0;
    check_eq("hold.inh", 32'(irq_inhibit), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("hold_rst.inh", 32'(irq_inhibit), 32'd0);
    check_write("hold_rst", 1'b0, 2'd0, 16'h0, 1'b0);

    // Normal sequence after reset
    ex_valid = 1'b1; ex_id = 2'd2; ex_data = 16'h5000;
    tick();
    ex_valid = 1'b0;
    check_write("post", 1'b1, 2'd2, 16'h5000, 1'b0);
    check_eq("post.inh", 32'(irq_inhibit), 32'd1);
    instr_done = 1'b1;
    tick();
    check_eq("post.inh_hold", 32'(irq_inhibit), 32'd1);
    tick();
    instr_done = 1'b0;
    check_eq("post.inh_drop", 32'(irq_inhibit), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
